mem_bus_unit: RTL and testbench

Data-memory bus interface unit between the pipeline MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It is the successor to the direct MEM-stage wiring: it holds each access on the bus until ACKD_n acknowledges it, and it stalls the pipeline while it waits. It also aligns and sign- or zero-extends sub-word loads, replicates store data across byte lanes, and reports misaligned or timed-out accesses. The unit adds endianness and timeout parameters that the direct wiring does not have.

---
 rtl/mem_bus_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_bus_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_unit.sv
// mem_bus_unit
// Data-memory bus interface between the pipeline MEM stage and the external
// data bus. Each access is held on the bus until ACKD_n acknowledges it, and
// the pipeline is stalled meanwhile. Sub-word loads are aligned and extended,
// store data is replicated across byte lanes, and misaligned or timed-out
// accesses are reported with a one-cycle err pulse.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid         MEM stage access request (held stable while stall=1)
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (misaligned)
//   req_signed        sign-extend byte/half loads
//   req_addr          byte address
//   req_wdata         right-justified store data
//   stall             freezes the pipeline registers
//   rdata             aligned/extended load data, valid with done
//   done              one-cycle pulse: access completed
//   err               one-cycle pulse: misaligned access or timeout
//   DAD               word-aligned bus address
//   DDT               bidirectional bus data, driven only for a store in BUS
//   MREQ, WRITE, SIZE bus request, write strobe, access size
//   ACKD_n            active-low bus acknowledge
module mem_bus_unit #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 15,
   parameter int BIG_ENDIAN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] DAD,
   inout  wire  [31:0]       DDT,
   output logic              MREQ,
   output logic              WRITE,
   output logic [1:0]        SIZE,
   input  logic              ACKD_n
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   // The counter holds the number of unacknowledged BUS cycles already spent;
   // reaching this value on a further unacknowledged cycle means timeout.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam bit BIG = (BIG_ENDIAN != 0);

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      DONE,
      ERR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic              write_q;
   logic [31:0]       wdata_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              mreq_q;
   logic              done_q;
   logic              err_q;
   logic [31:0]       rdata_q;

   logic              misaligned;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_data;
   logic [31:0]       store_data;

   // Size 11 is reserved and is rejected the same way as a misaligned access.
   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Lane selection: with BIG set the lowest address sits in the top byte.
   always_comb begin
      byte_sel = 8'h00;
      case (addr_q[1:0])
         2'd0:    byte_sel = BIG ? DDT[31:24] : DDT[7:0];
         2'd1:    byte_sel = BIG ? DDT[23:16] : DDT[15:8];
         2'd2:    byte_sel = BIG ? DDT[15:8]  : DDT[23:16];
         default: byte_sel = BIG ? DDT[7:0]   : DDT[31:24];
      endcase
      half_sel = (addr_q[1] ^ BIG) ? DDT[31:16] : DDT[15:0];

      load_data = DDT;
      case (size_q)
         2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
         default: load_data = DDT;
      endcase
   end

   // Replicating the store data means the memory picks its own lanes; the
   // unit never needs per-lane enables on DDT.
   always_comb begin
      store_data = wdata_q;
      case (size_q)
         2'b00:   store_data = {4{wdata_q[7:0]}};
         2'b01:   store_data = {2{wdata_q[15:0]}};
         default: store_data = wdata_q;
      endcase
   end

   // Control FSM. done/err/mreq are registered so they come straight off
   // flops; the async reset drops MREQ and floats DDT without waiting for a
   // clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= 32'h0;
         wait_cnt <= '0;
         mreq_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  write_q  <= req_write;
                  wdata_q  <= req_wdata;
                  wait_cnt <= '0;
                  if (misaligned) begin
                     state   <= ERR;
                     err_q   <= 1'b1;
                     rdata_q <= 32'h0;
                  end else begin
                     state  <= BUS;
                     mreq_q <= 1'b1;
                  end
               end
            end
            BUS: begin
               // An acknowledge on the timeout edge still completes the access.
               if (!ACKD_n) begin
                  state   <= DONE;
                  done_q  <= 1'b1;
                  mreq_q  <= 1'b0;
                  rdata_q <= write_q ? 32'h0 : load_data;
               end else if ((TIMEOUT_CYC != 0) && (wait_cnt == CNT_LAST)) begin
                  state   <= ERR;
                  err_q   <= 1'b1;
                  mreq_q  <= 1'b0;
                  rdata_q <= 32'h0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stall = ((state == IDLE) && req_valid) || (state == BUS);
   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;
   assign MREQ  = mreq_q;
   assign WRITE = mreq_q & write_q;
   assign DAD   = mreq_q ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign SIZE  = mreq_q ? size_q : 2'b00;
   assign DDT   = (mreq_q && write_q) ? store_data : {32{1'bz}};

endmodule

// File: tb/tb_mem_bus_unit.sv
// tb_mem_bus_unit
// Self-checking bench for mem_bus_unit. A driver issues directed and random
// accesses, a bus responder answers them with a chosen number of wait states,
// and a monitor compares every bus cycle and every done/err pulse against
// expectations queued by the driver from a behavioural model.
module tb_mem_bus_unit;

   localparam int TIMEOUT_CYC = 15;
   localparam int BIG_ENDIAN  = 1;

   typedef struct {
      bit          is_err;
      logic [31:0] rdata;
      int          bus_cycles;
      logic [31:0] dad;
      logic [1:0]  size;
      bit          write;
      logic [31:0] ddt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        done;
   logic        err;
   logic [31:0] dad;
   wire  [31:0] ddt_bus;
   logic        mreq;
   logic        write_s;
   logic [1:0]  size_s;
   logic        ackd_n;

   logic        ddt_en;
   logic [31:0] ddt_drv;
   int          cur_waits;
   logic [31:0] cur_busdata;

   exp_t        exp_q[$];
   int          checks;
   int          errors;

   assign ddt_bus = ddt_en ? ddt_drv : {32{1'bz}};

   mem_bus_unit #(
      .ADDR_W(32),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .BIG_ENDIAN(BIG_ENDIAN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_write(req_write),
      .req_size(req_size),
      .req_signed(req_signed),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .stall(stall),
      .rdata(rdata),
      .done(done),
      .err(err),
      .DAD(dad),
      .DDT(ddt_bus),
      .MREQ(mreq),
      .WRITE(write_s),
      .SIZE(size_s),
      .ACKD_n(ackd_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the DUT wedges somewhere the bounded waits miss.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no end of test, want end before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
      end
   endtask

   // Reference model: response derived from the access rules with plain
   // arithmetic on byte offsets.
   function automatic exp_t modelAccess(input bit wr, input logic [1:0] sz, input bit sgn,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input int waits, input logic [31:0] busdata);
      exp_t   e;
      int     k;
      int     nbytes;
      int     shift;
      longint val;
      k = int'(addr % 4);
      e.dad   = addr - 32'(k);
      e.size  = sz;
      e.write = wr;
      e.rdata = 32'h0;
      case (sz)
         2'd0:    e.ddt = (wdata & 32'hFF) * 32'h01010101;
         2'd1:    e.ddt = (wdata & 32'hFFFF) * 32'h00010001;
         default: e.ddt = wdata;
      endcase
      if (sz == 2'd3 || (addr % (32'd1 << sz)) != 0) begin
         e.is_err     = 1'b1;
         e.bus_cycles = 0;
      end else if (TIMEOUT_CYC != 0 && waits >= TIMEOUT_CYC) begin
         e.is_err     = 1'b1;
         e.bus_cycles = TIMEOUT_CYC;
      end else begin
         e.is_err     = 1'b0;
         e.bus_cycles = waits + 1;
         if (!wr) begin
            if (sz == 2'd2) begin
               e.rdata = busdata;
            end else begin
               nbytes = 1 << sz;
               shift  = (BIG_ENDIAN != 0) ? (4 - k - nbytes) * 8 : k * 8;
               val    = (longint'(busdata) >> shift) & ((64'd1 << (8 * nbytes)) - 1);
               if (sgn && val >= longint'(64'd1 << (8 * nbytes - 1)))
                  val = val - longint'(64'd1 << (8 * nbytes));
               e.rdata = val[31:0];
            end
         end
      end
      return e;
   endfunction

   // Issues one access from an IDLE-cycle negedge and waits for its response.
   // The request stays asserted through the completion cycle, as a stalled
   // pipeline would leave it, and is dropped in the following IDLE cycle.
   task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int waits, input logic [31:0] busdata);
      exp_t e;
      int   lat;
      bit   got;
      e = modelAccess(wr, sz, sgn, addr, wdata, waits, busdata);
      cur_waits   = waits;
      cur_busdata = busdata;
      exp_q.push_back(e);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      #1;
      checkOutput("accept_stall", {31'b0, stall}, 32'd1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (done || err) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL response_timeout: got no done/err in %0d cycles, want one", lat);
         exp_q.delete();
      end else begin
         checkOutput("latency", 32'(lat), 32'(e.bus_cycles + 1));
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Bus responder: acknowledges after cur_waits wait states and supplies load
   // data; outside BUS it toggles ACKD_n randomly, which the DUT must ignore.
   initial begin : responder
      int bus_cnt;
      bus_cnt = 0;
      ackd_n  = 1'b1;
      ddt_en  = 1'b0;
      ddt_drv = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus_cnt = 0;
            ackd_n  = 1'b1;
            ddt_en  = 1'b0;
         end else if (mreq) begin
            ackd_n  = (bus_cnt == cur_waits) ? 1'b0 : 1'b1;
            bus_cnt++;
            ddt_en  = !write_s;
            ddt_drv = cur_busdata;
         end else begin
            bus_cnt = 0;
            ddt_en  = 1'b0;
            ackd_n  = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: checks bus signals on every BUS cycle and each done/err pulse
   // against the oldest queued expectation.
   initial begin : monitor
      int   mcnt;
      exp_t e;
      mcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mcnt = 0;
         end else begin
            if (mreq) begin
               mcnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_bus_cycle: got MREQ=1, want no access");
               end else begin
                  e = exp_q[0];
                  checkOutput("bus_dad", dad, e.dad);
                  checkOutput("bus_size", {30'b0, size_s}, {30'b0, e.size});
                  checkOutput("bus_write", {31'b0, write_s}, {31'b0, e.write});
                  checkOutput("bus_stall", {31'b0, stall}, 32'd1);
                  if (e.write) checkOutput("bus_ddt", ddt_bus, e.ddt);
               end
            end
            if (done || err) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_response: got done=%0d err=%0d, want none", done, err);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("resp_kind", {30'b0, done, err}, e.is_err ? 32'd1 : 32'd2);
                  checkOutput("resp_stall", {31'b0, stall}, 32'd0);
                  checkOutput("resp_mreq", {30'b0, mreq, write_s}, 32'd0);
                  checkOutput("resp_bus_cycles", 32'(mcnt), 32'(e.bus_cycles));
                  if (e.is_err || !e.write) checkOutput("resp_rdata", rdata, e.rdata);
               end
               mcnt = 0;
            end
         end
      end
   end

   initial begin : driver
      exp_t        e;
      bit          wr;
      logic [1:0]  sz;
      bit          sgn;
      logic [31:0] addr;
      int          waits;
      int          r;
      checks      = 0;
      errors      = 0;
      cur_waits   = 0;
      cur_busdata = 32'h0;
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_size    = 2'b00;
      req_signed  = 1'b0;
      req_addr    = 32'h0;
      req_wdata   = 32'h0;

      repeat (2) @(negedge clk);
      checkOutput("reset_outputs", {26'b0, stall, done, err, mreq, write_s, |size_s}, 32'd0);
      checkOutput("reset_rdata", rdata, 32'h0);
      checkOutput("reset_dad", dad, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] directed accesses");
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h1234_5678);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 2, 32'h0000_00F0);
      applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 2, 32'h0000_00F0);
      applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'hABCD_1234, 0, 32'h0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0106, 32'h0, 0, 32'h0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 255, 32'h0);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_0500, 32'h0, 14, 32'h8001_7FFF);
      applyStimulus(1'b1, 2'd3, 1'b0, 32'h0000_0600, 32'h1, 0, 32'h0);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h0000_0701, 32'h0000_00C3, 1, 32'h0);

      $display("[TB] reset during a store bus cycle");
      e = modelAccess(1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h5A5A_A5A5, 255, 32'h0);
      exp_q.push_back(e);
      cur_waits  = 255;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = 32'h0000_0300;
      req_wdata  = 32'h5A5A_A5A5;
      repeat (3) @(negedge clk);
      checkOutput("pre_reset_mreq", {31'b0, mreq}, 32'd1);
      #2;
      rst       = 1'b1;
      req_valid = 1'b0;
      #1;
      checkOutput("async_reset_bus", {28'b0, mreq, write_s, done, err}, 32'd0);
      checkOutput("async_reset_dad", dad, 32'h0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D);

      $display("[TB] random accesses");
      for (int n = 0; n < 60; n++) begin
         wr   = 1'($urandom_range(0, 1));
         sgn  = 1'($urandom_range(0, 1));
         r    = int'($urandom_range(0, 9));
         sz   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) addr[0] = 1'b0;
            if (sz == 2'd2) addr[1:0] = 2'b00;
         end
         r = int'($urandom_range(0, 19));
         if (r < 14)      waits = int'($urandom_range(0, 3));
         else if (r < 16) waits = 14;
         else if (r < 18) waits = 15;
         else             waits = 255;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(wr, sz, sgn, addr, $urandom, waits, $urandom);
      end

      repeat (3) @(negedge clk);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
